// File: rtl/backend_powerup_ctrl.sv
// Power-up and calibration sequencer for the analog backend: applies gains, releases VCO and
// amplifier resets with programmable delays, and gates o_ready on a VCO frequency window check.
module backend_powerup_ctrl #(
  parameter int unsigned FREQ_W    = 11,
  parameter int unsigned FREQ_MIN  = 500,
  parameter int unsigned FREQ_MAX  = 600,
  parameter int unsigned VCO_DLY   = 2,
  parameter int unsigned AMP_DLY   = 10,
  parameter int unsigned RDY_DLY   = 10,
  parameter int unsigned SKIP_MEAS = 1,
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              i_clk,
  input  logic              i_resetAll,
  input  logic              i_cfg_valid,
  input  logic [1:0]        i_gainA1,
  input  logic [2:0]        i_gainA2,
  input  logic              i_freq_valid,
  input  logic [FREQ_W-1:0] i_vco_freq,
  output logic              o_resetbvco,
  output logic              o_resetb1,
  output logic              o_resetb2,
  output logic [1:0]        o_gainA1,
  output logic [2:0]        o_gainA2,
  output logic              o_ready,
  output logic              o_fault,
  output logic [2:0]        o_retry_cnt
);

  localparam int unsigned MAX_VA  = (VCO_DLY > AMP_DLY) ? VCO_DLY : AMP_DLY;
  localparam int unsigned MAX_DLY = (MAX_VA > RDY_DLY) ? MAX_VA : RDY_DLY;
  localparam int unsigned DLY_W   = $clog2(MAX_DLY + 1);
  localparam int unsigned SKIP_W  = (SKIP_MEAS > 0) ? $clog2(SKIP_MEAS + 1) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StVcoWait, StFreqCheck, StAmpWait, StSettle, StReady, StFault
  } state_e;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        retry_q, retry_d;
  logic [1:0]        gain1_q, gain1_d;
  logic [2:0]        gain2_q, gain2_d;
  logic              rbvco_q, rbvco_d;
  logic              rb1_q, rb1_d;
  logic              rb2_q, rb2_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  logic       in_window;
  logic       eval_pulse;
  logic       fail;
  logic [2:0] fail_cnt;
  logic [2:0] retry_inc;

  assign in_window  = (i_vco_freq >= FREQ_W'(FREQ_MIN)) && (i_vco_freq <= FREQ_W'(FREQ_MAX));
  assign eval_pulse = i_freq_valid && (skip_q == SKIP_W'(SKIP_MEAS));
  assign retry_inc  = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    gain1_d  = gain1_q;
    gain2_d  = gain2_q;
    rbvco_d  = rbvco_q;
    rb1_d    = rb1_q;
    rb2_d    = rb2_q;
    ready_d  = ready_q;
    fault_d  = fault_q;
    fail     = 1'b0;
    fail_cnt = retry_inc;

    // A new configuration restarts from any state and masks a coincident frequency sample.
    if (i_cfg_valid) begin
      state_d = StLoad;
      gain1_d = i_gainA1;
      gain2_d = i_gainA2;
      retry_d = '0;
      rbvco_d = 1'b0;
      rb1_d   = 1'b0;
      rb2_d   = 1'b0;
      ready_d = 1'b0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          state_d = StVcoWait;
          dly_d   = '0;
        end
        StVcoWait: begin
          if (dly_q == DLY_W'(VCO_DLY - 1)) begin
            state_d = StFreqCheck;
            rbvco_d = 1'b1;
            tmo_d   = '0;
            skip_d  = '0;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        StFreqCheck: begin
          tmo_d = tmo_q + 1'b1;
          if (i_freq_valid && !eval_pulse) skip_d = skip_q + 1'b1;
          if (eval_pulse && in_window) begin
            state_d = StAmpWait;
            dly_d   = '0;
          end else if (eval_pulse || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
            fail = 1'b1;
          end
        end
        StAmpWait: begin
          if (dly_q == DLY_W'(AMP_DLY - 1)) begin
            state_d = StSettle;
            rb1_d   = 1'b1;
            rb2_d   = 1'b1;
            dly_d   = '0;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        StSettle: begin
          if (dly_q == DLY_W'(RDY_DLY - 1)) begin
            state_d = StReady;
            ready_d = 1'b1;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        StReady: begin
          // Loss of lock starts a fresh retry sequence.
          if (i_freq_valid && !in_window) begin
            fail     = 1'b1;
            fail_cnt = 3'd1;
          end
        end
        default: ;
      endcase

      if (fail) begin
        retry_d = fail_cnt;
        rbvco_d = 1'b0;
        rb1_d   = 1'b0;
        rb2_d   = 1'b0;
        ready_d = 1'b0;
        dly_d   = '0;
        if (fail_cnt == 3'(MAX_RETRY)) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else begin
          state_d = StVcoWait;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      state_q <= StIdle;
      dly_q   <= '0;
      skip_q  <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      gain1_q <= '0;
      gain2_q <= '0;
      rbvco_q <= 1'b0;
      rb1_q   <= 1'b0;
      rb2_q   <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      gain1_q <= gain1_d;
      gain2_q <= gain2_d;
      rbvco_q <= rbvco_d;
      rb1_q   <= rb1_d;
      rb2_q   <= rb2_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign o_resetbvco = rbvco_q;
  assign o_resetb1   = rb1_q;
  assign o_resetb2   = rb2_q;
  assign o_gainA1    = gain1_q;
  assign o_gainA2    = gain2_q;
  assign o_ready     = ready_q;
  assign o_fault     = fault_q;
  assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_backend_powerup_ctrl.sv
// Bench for backend_powerup_ctrl: directed bring-up, window, retry, timeout, abort and reset
// scenarios plus random traffic, all checked against a phase/countdown reference model.
module tb_backend_powerup_ctrl;

  localparam int unsigned FMIN = 500;
  localparam int unsigned FMAX = 600;
  localparam int unsigned VDLY = 2;
  localparam int unsigned ADLY = 10;
  localparam int unsigned RDLY = 10;
  localparam int unsigned SKIP = 1;
  localparam int unsigned TMO  = 1023;
  localparam int unsigned MAXR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg = 1'b0;
  logic [1:0]  ga1 = '0;
  logic [2:0]  ga2 = '0;
  logic        fv  = 1'b0;
  logic [10:0] freq = '0;
  logic        o_resetbvco, o_resetb1, o_resetb2, o_ready, o_fault;
  logic [1:0]  o_gainA1;
  logic [2:0]  o_gainA2;
  logic [2:0]  o_retry_cnt;

  always #5 clk = ~clk;

  backend_powerup_ctrl #(
    .FREQ_W(11), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .VCO_DLY(VDLY), .AMP_DLY(ADLY),
    .RDY_DLY(RDLY), .SKIP_MEAS(SKIP), .TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .i_clk(clk), .i_resetAll(rst), .i_cfg_valid(cfg), .i_gainA1(ga1), .i_gainA2(ga2),
    .i_freq_valid(fv), .i_vco_freq(freq), .o_resetbvco(o_resetbvco), .o_resetb1(o_resetb1),
    .o_resetb2(o_resetb2), .o_gainA1(o_gainA1), .o_gainA2(o_gainA2), .o_ready(o_ready),
    .o_fault(o_fault), .o_retry_cnt(o_retry_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a named phase plus countdowns of cycles remaining.
  typedef enum int {MIdle, MLoad, MVco, MChk, MAmp, MSettle, MReady, MFault} mphase_e;
  mphase_e m_phase = MIdle;
  int m_left = 0, m_skip_left = 0, m_tmo_left = 0;
  int m_g1 = 0, m_g2 = 0, m_retry = 0;

  function automatic bit win(int f);
    return (f >= int'(FMIN)) && (f <= int'(FMAX));
  endfunction

  task automatic m_reset();
    m_phase = MIdle; m_left = 0; m_g1 = 0; m_g2 = 0; m_retry = 0;
  endtask

  task automatic m_fail(int cnt);
    m_retry = cnt;
    if (cnt == int'(MAXR)) m_phase = MFault;
    else begin m_phase = MVco; m_left = VDLY; end
  endtask

  task automatic model_step();
    bit ev;
    if (cfg) begin
      m_phase = MLoad; m_g1 = int'(ga1); m_g2 = int'(ga2); m_retry = 0;
      return;
    end
    case (m_phase)
      MLoad: begin m_phase = MVco; m_left = VDLY; end
      MVco: begin
        m_left--;
        if (m_left == 0) begin m_phase = MChk; m_skip_left = SKIP; m_tmo_left = TMO; end
      end
      MChk: begin
        ev = fv && (m_skip_left == 0);
        if (fv && m_skip_left > 0) m_skip_left--;
        m_tmo_left--;
        if (ev && win(int'(freq))) begin m_phase = MAmp; m_left = ADLY; end
        else if (ev || m_tmo_left == 0) m_fail((m_retry >= 7) ? 7 : m_retry + 1);
      end
      MAmp: begin
        m_left--;
        if (m_left == 0) begin m_phase = MSettle; m_left = RDLY; end
      end
      MSettle: begin
        m_left--;
        if (m_left == 0) m_phase = MReady;
      end
      MReady: if (fv && !win(int'(freq))) m_fail(1);
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("m_rbvco", 32'(o_resetbvco), 32'(m_phase inside {MChk, MAmp, MSettle, MReady}));
    chk("m_rb1", 32'(o_resetb1), 32'(m_phase inside {MSettle, MReady}));
    chk("m_rb2", 32'(o_resetb2), 32'(m_phase inside {MSettle, MReady}));
    chk("m_ready", 32'(o_ready), 32'(m_phase == MReady));
    chk("m_fault", 32'(o_fault), 32'(m_phase == MFault));
    chk("m_gain1", 32'(o_gainA1), 32'(m_g1));
    chk("m_gain2", 32'(o_gainA2), 32'(m_g2));
    chk("m_retry", 32'(o_retry_cnt), 32'(m_retry));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    cfg = 1'b0;
    fv  = 1'b0;
  endtask

  task automatic run_to(input mphase_e target, input int budget);
    int n = 0;
    while (m_phase != target && n < budget) begin
      if (m_phase == MChk && $urandom_range(0, 2) == 0) begin
        fv = 1'b1;
        freq = 11'($urandom_range(FMIN, FMAX));
      end
      tick();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL run_to observed_phase=%0d required_phase=%0d", m_phase, target);
    end
  endtask

  task automatic start(input logic [1:0] g1, input logic [2:0] g2);
    ga1 = g1; ga2 = g2; cfg = 1'b1;
    tick();
  endtask

  int wv[4]   = '{499, 500, 600, 601};
  int wvco[4] = '{0, 1, 1, 0};
  int wret[4] = '{1, 0, 0, 1};

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_outputs();
    #4 rst = 1'b0;
    repeat (3) begin
      fv = 1'b1; freq = 11'd550;
      tick();
    end

    // Nominal bring-up
    start(2'b10, 3'b101);
    chk("nom_gain1", 32'(o_gainA1), 32'h2);
    chk("nom_gain2", 32'(o_gainA2), 32'h5);
    tick();
    tick();
    chk("nom_vco_early", 32'(o_resetbvco), 32'h0);
    tick();
    chk("nom_vco_rise", 32'(o_resetbvco), 32'h1);
    fv = 1'b1; freq = 11'd0;
    tick();
    fv = 1'b1; freq = 11'd550;
    tick();
    repeat (9) tick();
    chk("nom_amp_early", 32'(o_resetb1), 32'h0);
    tick();
    chk("nom_amp_rise1", 32'(o_resetb1), 32'h1);
    chk("nom_amp_rise2", 32'(o_resetb2), 32'h1);
    repeat (9) tick();
    chk("nom_rdy_early", 32'(o_ready), 32'h0);
    tick();
    chk("nom_rdy_rise", 32'(o_ready), 32'h1);
    chk("nom_retry", 32'(o_retry_cnt), 32'h0);

    // Window edges
    for (int i = 0; i < 4; i++) begin
      start(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      run_to(MChk, 20);
      fv = 1'b1; freq = 11'd0;
      tick();
      fv = 1'b1; freq = 11'(wv[i]);
      tick();
      chk("win_vco", 32'(o_resetbvco), 32'(wvco[i]));
      chk("win_retry", 32'(o_retry_cnt), 32'(wret[i]));
    end

    // Retry to fault, then recovery
    start(2'b01, 3'b010);
    for (int r = 1; r <= 3; r++) begin
      run_to(MChk, 20);
      fv = 1'b1; freq = 11'd0;
      tick();
      fv = 1'b1; freq = 11'd700;
      tick();
      chk("retry_step", 32'(o_retry_cnt), 32'(r));
    end
    chk("fault_set", 32'(o_fault), 32'h1);
    chk("fault_vco", 32'(o_resetbvco), 32'h0);
    chk("fault_gain", 32'(o_gainA2), 32'h2);
    repeat (5) begin
      fv = 1'b1; freq = 11'd550;
      tick();
    end
    start(2'b11, 3'b110);
    chk("fault_clear", 32'(o_fault), 32'h0);
    chk("fault_newgain", 32'(o_gainA1), 32'h3);

    // Timeout
    run_to(MChk, 20);
    repeat (TMO - 1) tick();
    chk("tmo_before", 32'(o_retry_cnt), 32'h0);
    chk("tmo_vco_before", 32'(o_resetbvco), 32'h1);
    tick();
    chk("tmo_retry", 32'(o_retry_cnt), 32'h1);
    chk("tmo_vco", 32'(o_resetbvco), 32'h0);

    // Loss of lock
    run_to(MReady, 100);
    fv = 1'b1; freq = 11'd300;
    tick();
    chk("lol_ready", 32'(o_ready), 32'h0);
    chk("lol_vco", 32'(o_resetbvco), 32'h0);
    chk("lol_rb1", 32'(o_resetb1), 32'h0);
    chk("lol_retry", 32'(o_retry_cnt), 32'h1);

    // Abort during SETTLE with a coincident frequency sample
    run_to(MSettle, 100);
    ga1 = 2'b01; ga2 = 3'b011; cfg = 1'b1; fv = 1'b1; freq = 11'd300;
    tick();
    chk("abort_gain1", 32'(o_gainA1), 32'h1);
    chk("abort_gain2", 32'(o_gainA2), 32'h3);
    chk("abort_vco", 32'(o_resetbvco), 32'h0);
    chk("abort_rb1", 32'(o_resetb1), 32'h0);
    chk("abort_retry", 32'(o_retry_cnt), 32'h0);

    // Asynchronous reset mid-cycle in AMP_WAIT
    run_to(MAmp, 100);
    #3 rst = 1'b1;
    #1;
    chk("arst_vco", 32'(o_resetbvco), 32'h0);
    chk("arst_rb1", 32'(o_resetb1), 32'h0);
    chk("arst_gain1", 32'(o_gainA1), 32'h0);
    chk("arst_gain2", 32'(o_gainA2), 32'h0);
    m_reset();
    #1 rst = 1'b0;
    repeat (20) begin
      fv = 1'($urandom_range(0, 1)); freq = 11'($urandom_range(400, 700));
      tick();
    end

    // Random traffic
    repeat (600) begin
      if ($urandom_range(0, 59) == 0) begin
        cfg = 1'b1; ga1 = 2'($urandom_range(0, 3)); ga2 = 3'($urandom_range(0, 7));
      end
      fv = ($urandom_range(0, 3) == 0);
      freq = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047))
                                         : 11'($urandom_range(480, 620));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
